fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_if.sv | 31 +++
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the PC, instruction-memory, decode and redirect signals of the
// fetch controller.
//   master - the fetch controller: drives prox_end, halt, mem_req, mem_addr, instr,
//            instr_valid, fetch_err; observes pc, mem_ready, mem_data, instr_ack,
//            branch_taken, branch_target.
//   slave  - the surrounding pipeline/memory: the mirror image of master.
interface fetch_ctrl_if;
    logic [31:0] pc;
    logic [31:0] prox_end;
    logic        halt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        fetch_err;

    modport master (
        input  pc, mem_ready, mem_data, instr_ack, branch_taken, branch_target,
        output prox_end, halt, mem_req, mem_addr, instr, instr_valid, fetch_err
    );

    modport slave (
        output pc, mem_ready, mem_data, instr_ack, branch_taken, branch_target,
        input  prox_end, halt, mem_req, mem_addr, instr, instr_valid, fetch_err
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. Requests the word at pc, waits for memory
// (with a timeout), offers the word to decode and computes the next PC value once the
// word is accepted. Redirects arriving before acceptance squash the in-flight word.
// Ports:
//   clock - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - fetch_ctrl_if.master (PC, memory, decode and redirect signals)
module fetch_ctrl #(
    parameter logic [5:0]  HALT_OPCODE = 6'h3F,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.master bus
);
    localparam int unsigned     CntW   = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);
    localparam logic [5:0]      OpJ    = 6'h02;
    localparam logic [5:0]      OpJal  = 6'h03;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StHalted} state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CntW-1:0]   wait_cnt_inc;
    logic              redir_valid_q, redir_valid_d;
    logic [31:0]       redir_target_q, redir_target_d;
    logic [31:0]       instr_q, instr_d;
    logic              fetch_err_q, fetch_err_d;

    logic [31:0]       pc_plus4;
    logic [5:0]        opcode;
    logic              halt, mem_req, instr_valid;
    logic [31:0]       prox_end;

    assign pc_plus4     = bus.pc + 32'd4;
    assign opcode       = instr_q[31:26];
    assign wait_cnt_inc = wait_cnt_q + CntW'(1);

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        redir_valid_d  = redir_valid_q;
        redir_target_d = redir_target_q;
        instr_d        = instr_q;
        fetch_err_d    = fetch_err_q;
        halt           = 1'b1;
        mem_req        = 1'b0;
        instr_valid    = 1'b0;
        prox_end       = bus.pc;

        unique case (state_q)
            StIdle: state_d = StReq;

            StReq, StWait: begin
                mem_req = 1'b1;
                if (bus.branch_taken) begin
                    redir_valid_d  = 1'b1;
                    redir_target_d = bus.branch_target;
                end
                if (bus.mem_ready) begin
                    // Latched even when a redirect will squash it; instr_valid gates use.
                    instr_d = bus.mem_data;
                    state_d = StDone;
                end else if (state_q == StReq) begin
                    wait_cnt_d = '0;
                    state_d    = StWait;
                end else if (wait_cnt_inc == CntMax) begin
                    fetch_err_d = 1'b1;
                    state_d     = StHalted;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end

            StDone: begin
                if (redir_valid_q) begin
                    // Squash advance: drop the word and move the PC to the redirect.
                    // A redirect arriving in this very cycle is the newest and wins.
                    halt          = 1'b0;
                    prox_end      = bus.branch_taken ? bus.branch_target : redir_target_q;
                    redir_valid_d = 1'b0;
                    state_d       = StReq;
                end else begin
                    instr_valid = 1'b1;
                    if (bus.instr_ack) begin
                        halt = 1'b0;
                        if (bus.branch_taken) begin
                            prox_end = bus.branch_target;
                        end else if (opcode == OpJ || opcode == OpJal) begin
                            prox_end = {pc_plus4[31:28], instr_q[25:0], 2'b00};
                        end else begin
                            prox_end = pc_plus4;
                        end
                        state_d = (opcode == HALT_OPCODE) ? StHalted : StReq;
                    end else if (bus.branch_taken) begin
                        redir_valid_d  = 1'b1;
                        redir_target_d = bus.branch_target;
                    end
                end
            end

            StHalted: redir_valid_d = 1'b0;

            default: state_d = StIdle;
        endcase

        // Hold the interface at its reset values while reset is asserted.
        if (reset) begin
            halt        = 1'b1;
            mem_req     = 1'b0;
            instr_valid = 1'b0;
            prox_end    = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            wait_cnt_q     <= '0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= '0;
            instr_q        <= '0;
            fetch_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
            instr_q        <= instr_d;
            fetch_err_q    <= fetch_err_d;
        end
    end

    assign bus.prox_end    = prox_end;
    assign bus.halt        = halt;
    assign bus.mem_req     = mem_req;
    assign bus.mem_addr    = mem_req ? bus.pc : 32'd0;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid;
    assign bus.fetch_err   = fetch_err_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed, self-checking bench for fetch_ctrl. The bench plays the PC
// register, instruction memory, decode and execute stages by driving the interface.
module tb_fetch_ctrl;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .HALT_OPCODE (6'h3F),
        .MEM_TIMEOUT (255)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic rdy, input logic [31:0] data,
                          input logic ack, input logic br, input logic [31:0] tgt);
        bus.pc            = pc;
        bus.mem_ready     = rdy;
        bus.mem_data      = data;
        bus.instr_ack     = ack;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        #1;
    endtask

    // Leaves the DUT in IDLE with reset low, inputs quiet.
    task automatic do_reset();
        reset = 1'b1;
        set_in(32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_prox_end", bus.prox_end, 32'h0);
        check("rst_halt", {31'b0, bus.halt}, 32'd1);
        check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("rst_fetch_err", {31'b0, bus.fetch_err}, 32'd0);
        reset = 1'b0;
        set_in(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("idle_mem_req", {31'b0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        @(posedge clock);
        #2;

        // Zero-wait memory, ack held: fetch every two cycles.
        do_reset();
        set_in(32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        check("zw_req", {31'b0, bus.mem_req}, 32'd1);
        check("zw_addr", bus.mem_addr, 32'h0);
        check("zw_req_halt", {31'b0, bus.halt}, 32'd1);
        tick();
        check("zw_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("zw_hs_halt", {31'b0, bus.halt}, 32'd0);
        check("zw_hs_prox", bus.prox_end, 32'h4);
        tick();
        check("zw_req2", {31'b0, bus.mem_req}, 32'd1);
        check("zw_valid2_low", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        check("zw_valid2", {31'b0, bus.instr_valid}, 32'd1);

        // Jump target composition.
        do_reset();
        set_in(32'h0040_0010, 1'b1, 32'h0800_0100, 1'b1, 1'b0, 32'h0);
        tick();
        check("j_addr", bus.mem_addr, 32'h0040_0010);
        tick();
        check("j_instr", bus.instr, 32'h0800_0100);
        check("j_halt", {31'b0, bus.halt}, 32'd0);
        check("j_prox", bus.prox_end, 32'h0000_0400);
        tick();
        check("j_halt_after", {31'b0, bus.halt}, 32'd1);
        check("j_prox_after", bus.prox_end, 32'h0040_0010);

        // PC wrap at the top of the address space.
        do_reset();
        set_in(32'hFFFF_FFFC, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        check("wrap_prox", bus.prox_end, 32'h0);

        // Redirect during WAIT squashes the returned word.
        do_reset();
        set_in(32'h40, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        set_in(32'h40, 1'b0, 32'h1111_1111, 1'b1, 1'b1, 32'h80);
        check("br_wait_req", {31'b0, bus.mem_req}, 32'd1);
        check("br_wait_prox", bus.prox_end, 32'h40);
        tick();
        set_in(32'h40, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        check("br_wait2_valid", {31'b0, bus.instr_valid}, 32'd0);
        tick();
        set_in(32'h40, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        tick();
        set_in(32'h40, 1'b0, 32'h1111_1111, 1'b1, 1'b0, 32'h0);
        check("sq_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("sq_halt", {31'b0, bus.halt}, 32'd0);
        check("sq_prox", bus.prox_end, 32'h80);
        bus.pc = 32'h80;
        tick();
        check("sq_req", {31'b0, bus.mem_req}, 32'd1);
        check("sq_addr", bus.mem_addr, 32'h80);
        check("sq_req_halt", {31'b0, bus.halt}, 32'd1);

        // Redirect in DONE without ack withdraws the offer next cycle.
        do_reset();
        set_in(32'h600, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("dbr_valid", {31'b0, bus.instr_valid}, 32'd1);
        set_in(32'h600, 1'b0, 32'h0000_0001, 1'b0, 1'b1, 32'h700);
        check("dbr_halt", {31'b0, bus.halt}, 32'd1);
        check("dbr_prox", bus.prox_end, 32'h600);
        tick();
        set_in(32'h600, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 32'h0);
        check("dbr_sq_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("dbr_sq_halt", {31'b0, bus.halt}, 32'd0);
        check("dbr_sq_prox", bus.prox_end, 32'h700);

        // HALT opcode: delivered once, then stopped until reset.
        do_reset();
        set_in(32'h100, 1'b1, 32'hFC00_0000, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        check("hlt_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("hlt_instr", bus.instr, 32'hFC00_0000);
        check("hlt_hs_halt", {31'b0, bus.halt}, 32'd0);
        check("hlt_hs_prox", bus.prox_end, 32'h104);
        set_in(32'h104, 1'b1, 32'hFC00_0000, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hlt_mem_req", {31'b0, bus.mem_req}, 32'd0);
            check("hlt_halt", {31'b0, bus.halt}, 32'd1);
            check("hlt_valid_low", {31'b0, bus.instr_valid}, 32'd0);
            check("hlt_prox", bus.prox_end, 32'h104);
        end
        do_reset();
        tick();
        check("hlt_restart_req", {31'b0, bus.mem_req}, 32'd1);

        // Memory timeout.
        do_reset();
        set_in(32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 254; i++) tick();
        check("to_last_wait_err", {31'b0, bus.fetch_err}, 32'd0);
        check("to_last_wait_req", {31'b0, bus.mem_req}, 32'd1);
        tick();
        check("to_err", {31'b0, bus.fetch_err}, 32'd1);
        check("to_req_off", {31'b0, bus.mem_req}, 32'd0);
        set_in(32'h300, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_err_sticky", {31'b0, bus.fetch_err}, 32'd1);
            check("to_halted_valid", {31'b0, bus.instr_valid}, 32'd0);
        end
        do_reset();

        // Reset mid-WAIT; a late mem_ready in IDLE is ignored.
        set_in(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_in(32'h40, 1'b1, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
        check("late_idle_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("late_idle_req", {31'b0, bus.mem_req}, 32'd0);
        tick();
        check("late_req_valid", {31'b0, bus.instr_valid}, 32'd0);
        check("late_instr", bus.instr, 32'h0);

        // Decode stall for 10 cycles, then ack together with a redirect.
        do_reset();
        set_in(32'h500, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        set_in(32'h500, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            check("stall_instr", bus.instr, 32'h1234_5678);
            check("stall_valid", {31'b0, bus.instr_valid}, 32'd1);
            check("stall_halt", {31'b0, bus.halt}, 32'd1);
            check("stall_prox", bus.prox_end, 32'h500);
            tick();
        end
        set_in(32'h500, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h100);
        check("stall_ack_halt", {31'b0, bus.halt}, 32'd0);
        check("stall_ack_prox", bus.prox_end, 32'h100);
        bus.pc = 32'h100;
        bus.branch_taken = 1'b0;
        tick();
        check("stall_next_req", {31'b0, bus.mem_req}, 32'd1);
        check("stall_next_addr", bus.mem_addr, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
